operand_loader: RTL and testbench

Upstream feeder for the 64-bit add/sub/comp/mux/shift datapaths. It assembles three DATAWIDTH-bit operands (a, b, c) from a narrow BUSWIDTH-bit word stream under valid/ready flow control. Completed operand bundles are presented on parallel outputs under a second valid/ready handshake. A staging buffer plus an output buffer (two bundles deep) lets the next bundle fill while the current one waits to be consumed.

---
 rtl/operand_loader_if.sv | 32 +++
 rtl/operand_loader.sv | 133 +++++++++++++
 tb/tb_operand_loader.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_loader_if.sv
// Bus bundle for operand_loader: narrow word stream in, parallel a/b/c bundle out,
// plus debug visibility of the staging state and word counter.
interface operand_loader_if #(
  parameter int DATAWIDTH = 64,
  parameter int BUSWIDTH  = 32
);
  localparam int KW = $clog2(3 * (DATAWIDTH / BUSWIDTH) + 2);

  // Both channels transfer on a rising edge where valid && ready; a source holds
  // its data stable while valid is high and ready is low.
  logic [BUSWIDTH-1:0]  in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] a;
  logic [DATAWIDTH-1:0] b;
  logic [DATAWIDTH-1:0] c;
  logic                 out_valid;
  logic                 out_ready;
  logic                 err;
  logic                 dbg_full;
  logic [KW-1:0]        dbg_k;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, a, b, c, out_valid, err, dbg_full, dbg_k
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, a, b, c, out_valid, err, dbg_full, dbg_k
  );
endinterface

// File: rtl/operand_loader.sv
// Assembles a, b, c operands from a BUSWIDTH word stream into a staging buffer and
// hands completed bundles to an output buffer. Define OPERAND_LOADER_CHECKSUM_EN for a trailing XOR word.
module operand_loader #(
  parameter int DATAWIDTH = 64,
  parameter int BUSWIDTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  operand_loader_if.slave   bus
);
  localparam int N  = DATAWIDTH / BUSWIDTH;
  localparam int W  = 3 * N;
`ifdef OPERAND_LOADER_CHECKSUM_EN
  localparam int WT = W + 1;
`else
  localparam int WT = W;
`endif
  localparam int KW = $clog2(W + 2);

  typedef enum logic {
    ST_FILL,
    ST_FULL
  } stage_state_t;

  stage_state_t                  state_q, state_nxt;
  logic [KW-1:0]                 k_q, k_nxt;
  logic [W-1:0][BUSWIDTH-1:0]    stage_q, stage_nxt;
  logic [DATAWIDTH-1:0]          a_q, b_q, c_q;
  logic                          out_valid_q, out_valid_nxt;
  logic                          accept;
  logic                          last;
  logic                          chk_ok;
  logic                          mismatch;
  logic                          xfer;

  assign bus.in_ready = rst && (state_q == ST_FILL);
  assign accept       = bus.in_valid && bus.in_ready;
  assign last         = accept && (k_q == KW'(WT - 1));

`ifdef OPERAND_LOADER_CHECKSUM_EN
  logic [BUSWIDTH-1:0] chk_xor;
  logic                err_q;

  // The checksum word is never stored; it is compared against the full staging buffer.
  always_comb begin
    chk_xor = '0;
    for (int i = 0; i < W; i++) begin
      chk_xor = chk_xor ^ stage_q[i];
    end
  end
  assign chk_ok = (chk_xor == bus.in_data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= mismatch;
    end
  end
  assign bus.err = err_q;
`else
  assign chk_ok  = 1'b1;
  assign bus.err = 1'b0;
`endif

  assign mismatch = last && !chk_ok;

  always_comb begin
    stage_nxt     = stage_q;
    k_nxt         = k_q;
    state_nxt     = state_q;
    out_valid_nxt = out_valid_q;
    xfer          = 1'b0;

    for (int i = 0; i < W; i++) begin
      if (accept && (k_q == KW'(i))) begin
        stage_nxt[i] = bus.in_data;
      end
    end
    if (accept) begin
      k_nxt = k_q + 1'b1;
    end

    // A bundle completing this edge moves straight out if the output slot frees up.
    if ((last && chk_ok) || (state_q == ST_FULL)) begin
      if (!out_valid_q || bus.out_ready) begin
        xfer          = 1'b1;
        k_nxt         = '0;
        state_nxt     = ST_FILL;
        out_valid_nxt = 1'b1;
      end else begin
        state_nxt = ST_FULL;
      end
    end else begin
      if (mismatch) begin
        k_nxt = '0;
      end
      if (out_valid_q && bus.out_ready) begin
        out_valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FILL;
      k_q         <= '0;
      stage_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      k_q         <= k_nxt;
      stage_q     <= stage_nxt;
      out_valid_q <= out_valid_nxt;
      if (xfer) begin
        a_q <= stage_nxt[N-1:0];
        b_q <= stage_nxt[2*N-1:N];
        c_q <= stage_nxt[3*N-1:2*N];
      end
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.c         = c_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dbg_full  = (state_q == ST_FULL);
  assign bus.dbg_k     = k_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: table of bundles with hand-computed operands,
// plus sequences for backpressure, replacement, reset mid-fill, gaps and checksum.
module tb_operand_loader;
  localparam int DW = 64;
  localparam int BW = 32;
  localparam int N  = DW / BW;
  localparam int W  = 3 * N;
`ifdef OPERAND_LOADER_CHECKSUM_EN
  localparam int WT = W + 1;
`else
  localparam int WT = W;
`endif

  typedef struct packed {
    logic [W-1:0][BW-1:0] w;
    logic [DW-1:0]        a;
    logic [DW-1:0]        b;
    logic [DW-1:0]        c;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [3*DW-1:0] exp_q[$];
  vec_t vecs[3];
  vec_t cv;

  operand_loader_if #(.DATAWIDTH(DW), .BUSWIDTH(BW)) bus ();

  operand_loader #(.DATAWIDTH(DW), .BUSWIDTH(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "bench watchdog expired");
  end

  task automatic check(input string name, input logic [3*DW-1:0] act, input logic [3*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // scoreboard: every consumed bundle must match the next expected one
  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bundle_unexpected actual=%h required=none", {bus.a, bus.b, bus.c});
      end else begin
        check("bundle_consumed", {bus.a, bus.b, bus.c}, exp_q.pop_front());
      end
    end
  end

  // drivers
  function automatic logic [WT-1:0][BW-1:0] words_of(input vec_t v);
    logic [WT-1:0][BW-1:0] r;
`ifdef OPERAND_LOADER_CHECKSUM_EN
    logic [BW-1:0] x;
    x = '0;
    for (int i = 0; i < W; i++) x = x ^ v.w[i];
`endif
    r = '0;
    for (int i = 0; i < W; i++) r[i] = v.w[i];
`ifdef OPERAND_LOADER_CHECKSUM_EN
    r[W] = x;
`endif
    return r;
  endfunction

  task automatic send_word(input logic [BW-1:0] w);
    bit got;
    got = 1'b0;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = BW'($urandom);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_timeout actual=in_ready_low required=accepted word=%h", w);
    end
  endtask

  task automatic send_bundle(input vec_t v, input bit gap);
    logic [WT-1:0][BW-1:0] ws;
    ws = words_of(v);
    for (int i = 0; i < WT; i++) begin
      send_word(ws[i]);
      if (gap && i < WT - 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  // call at the negedge following the accepting edge
  task automatic check_out(input string name, input vec_t v);
    check({name, "_valid"}, bus.out_valid, 1'b1);
    check({name, "_abc"}, {bus.a, bus.b, bus.c}, {v.a, v.b, v.c});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WT-1:0][BW-1:0] ws;

    vecs[0].w = {32'h0, 32'h3, 32'h80000000, 32'h2, 32'h0, 32'h1};
    vecs[0].a = 64'h0000000000000001;
    vecs[0].b = 64'h8000000000000002;
    vecs[0].c = 64'h0000000000000003;
    vecs[1].w = {32'h0, 32'h0, 32'hffffffff, 32'hffffffff, 32'h01234567, 32'hdeadbeef};
    vecs[1].a = 64'h01234567deadbeef;
    vecs[1].b = 64'hffffffffffffffff;
    vecs[1].c = 64'h0000000000000000;
    vecs[2].w = {32'h0badf00d, 32'hcafef00d, 32'h22222222, 32'h11111111, 32'h01234567, 32'h89abcdef};
    vecs[2].a = 64'h0123456789abcdef;
    vecs[2].b = 64'h2222222211111111;
    vecs[2].c = 64'h0badf00dcafef00d;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_abc", {bus.a, bus.b, bus.c}, '0);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_in_ready", bus.in_ready, 1'b0);
    check("reset_err", bus.err, 1'b0);
    check("reset_k", bus.dbg_k, '0);
    tick();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_in_ready", bus.in_ready, 1'b1);
    tick();

    // table-driven bundles, consumer always ready
    bus.out_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      exp_q.push_back({vecs[v].a, vecs[v].b, vecs[v].c});
      send_bundle(vecs[v], 1'b0);
      @(negedge clk);
      check_out($sformatf("table%0d", v), vecs[v]);
      tick();
    end
    check("table_drained_valid", bus.out_valid, 1'b0);

    // last word accepted on the same edge the held bundle is consumed
    bus.out_ready = 1'b0;
    exp_q.push_back({vecs[1].a, vecs[1].b, vecs[1].c});
    exp_q.push_back({vecs[2].a, vecs[2].b, vecs[2].c});
    send_bundle(vecs[1], 1'b0);
    ws = words_of(vecs[2]);
    for (int i = 0; i < WT - 1; i++) send_word(ws[i]);
    bus.out_ready = 1'b1;
    send_word(ws[WT-1]);
    @(negedge clk);
    check_out("replace", vecs[2]);
    tick();
    check("replace_drained", bus.out_valid, 1'b0);
    check("replace_k", bus.dbg_k, '0);

    // backpressure: two bundles while the consumer stalls
    bus.out_ready = 1'b0;
    exp_q.push_back({vecs[0].a, vecs[0].b, vecs[0].c});
    exp_q.push_back({vecs[1].a, vecs[1].b, vecs[1].c});
    send_bundle(vecs[0], 1'b0);
    send_bundle(vecs[1], 1'b0);
    @(negedge clk);
    check("bp_in_ready", bus.in_ready, 1'b0);
    check_out("bp_hold", vecs[0]);
    repeat (3) tick();
    @(negedge clk);
    check("bp_still_stalled", bus.in_ready, 1'b0);
    check("bp_still_full", bus.dbg_full, 1'b1);
    check_out("bp_stable", vecs[0]);
    tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    check_out("bp_second", vecs[1]);
    check("bp_in_ready_back", bus.in_ready, 1'b1);
    tick();
    bus.out_ready = 1'b1;
    tick();
    check("bp_drained", bus.out_valid, 1'b0);

    // reset mid-fill discards partial words
    for (int i = 0; i < 3; i++) send_word(BW'($urandom_range(1, 32'hfffffffe)));
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_in_ready", bus.in_ready, 1'b0);
    check("rst_mid_k", bus.dbg_k, '0);
    check("rst_mid_abc", {bus.a, bus.b, bus.c}, '0);
    tick();
    rst = 1'b1;
    exp_q.push_back({vecs[2].a, vecs[2].b, vecs[2].c});
    send_bundle(vecs[2], 1'b0);
    @(negedge clk);
    check_out("rst_fresh", vecs[2]);
    tick();

    // gapped input
    exp_q.push_back({vecs[1].a, vecs[1].b, vecs[1].c});
    send_bundle(vecs[1], 1'b1);
    @(negedge clk);
    check_out("gapped", vecs[1]);
    tick();

`ifdef OPERAND_LOADER_CHECKSUM_EN
    cv.w = {32'h0, 32'h3, 32'h0, 32'h2, 32'h0, 32'h1};
    cv.a = 64'h1;
    cv.b = 64'h2;
    cv.c = 64'h3;
    exp_q.push_back({cv.a, cv.b, cv.c});
    for (int i = 0; i < W; i++) send_word(cv.w[i]);
    send_word(32'h0);
    @(negedge clk);
    check_out("chk_good", cv);
    check("chk_good_err", bus.err, 1'b0);
    tick();
    for (int i = 0; i < W; i++) send_word(cv.w[i]);
    send_word(32'h5);
    @(negedge clk);
    check("chk_bad_err", bus.err, 1'b1);
    check("chk_bad_valid", bus.out_valid, 1'b0);
    check("chk_bad_k", bus.dbg_k, '0);
    tick();
    @(negedge clk);
    check("chk_bad_err_pulse", bus.err, 1'b0);
    check("chk_bad_valid_after", bus.out_valid, 1'b0);
    tick();
`else
    cv = vecs[0];
    check("err_tied_low", bus.err, 1'b0);
`endif

    // final report
    repeat (2) tick();
    check("scoreboard_drain", 3*DW'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
